// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares one APB slave port between two on-chip requesters. Requests are
// arbitrated round-robin and run one at a time through the APB SETUP and
// ACCESS phases. The ACCESS phase waits on PREADY, with an optional bound on
// the number of wait states. Completion status comes back on a single
// ID-tagged response port.
//
// Ports
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   REQn_VALID/WRITE/ADDR/WDATA   requester n (n = 0, 1); fields held until GNTn
//   GNT0, GNT1                    one-cycle pulse: request captured
//   RSP_VALID                     one-cycle pulse: transfer finished
//   RSP_ID, RSP_RDATA, RSP_ERR,   response fields. They are valid with
//   RSP_TIMEOUT                   RSP_VALID and hold until the next response.
//   BUSY                          arbiter is not idle
//   PSELx, PENABLE, PWRITE,       APB master outputs
//   PADDR, PWDATA
//   PRDATA, PREADY, PSLVERR       APB slave returns
//
// Parameter
//   TIMEOUT_CYCLES                ACCESS cycles with PREADY=0 before abort;
//                                 0 waits forever
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,

    input  logic        REQ0_VALID,
    input  logic        REQ0_WRITE,
    input  logic [31:0] REQ0_ADDR,
    input  logic [31:0] REQ0_WDATA,
    input  logic        REQ1_VALID,
    input  logic        REQ1_WRITE,
    input  logic [31:0] REQ1_ADDR,
    input  logic [31:0] REQ1_WDATA,

    output logic        GNT0,
    output logic        GNT1,

    output logic        RSP_VALID,
    output logic        RSP_ID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_TIMEOUT,
    output logic        BUSY,

    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    // The counter must be able to hold TIMEOUT_CYCLES itself. When the
    // timeout is disabled, the counter is a single unused bit.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = TO_EN ? CW'(TIMEOUT_CYCLES) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_reg;
    logic          last_grant_reg;   // requester granted most recently
    logic          id_reg;           // requester owning the current transfer
    logic [CW-1:0] cnt_reg;          // wait states seen in ACCESS

    logic          any_req;
    logic          win_id;
    logic          win_write;
    logic [31:0]   win_addr;
    logic [31:0]   win_wdata;
    logic [CW-1:0] cnt_next;

    // Winner selection. A lone request always wins. On a tie, the requester
    // that was not granted last wins.
    always_comb begin
        any_req   = REQ0_VALID | REQ1_VALID;
        win_id    = REQ1_VALID & (~REQ0_VALID | ~last_grant_reg);
        win_write = win_id ? REQ1_WRITE : REQ0_WRITE;
        win_addr  = win_id ? REQ1_ADDR  : REQ0_ADDR;
        win_wdata = win_id ? REQ1_WDATA : REQ0_WDATA;
        cnt_next  = cnt_reg + CW'(1);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;      // REQ0 wins the first tie
            id_reg         <= 1'b0;
            cnt_reg        <= '0;
            GNT0           <= 1'b0;
            GNT1           <= 1'b0;
            RSP_VALID      <= 1'b0;
            RSP_ID         <= 1'b0;
            RSP_RDATA      <= '0;
            RSP_ERR        <= 1'b0;
            RSP_TIMEOUT    <= 1'b0;
            BUSY           <= 1'b0;
            PSELx          <= 1'b0;
            PENABLE        <= 1'b0;
            PWRITE         <= 1'b0;
            PADDR          <= '0;
            PWDATA         <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            RSP_VALID <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        PWRITE         <= win_write;
                        PADDR          <= win_addr;
                        PWDATA         <= win_wdata;
                        id_reg         <= win_id;
                        last_grant_reg <= win_id;
                        GNT0           <= ~win_id;
                        GNT1           <= win_id;
                        PSELx          <= 1'b1;
                        PENABLE        <= 1'b0;
                        BUSY           <= 1'b1;
                        state_reg      <= SETUP;
                    end
                end

                SETUP: begin
                    PENABLE   <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ACCESS;
                end

                ACCESS: begin
                    // PREADY takes priority over the timeout. A slave that
                    // answers on the last allowed cycle completes normally.
                    if (PREADY) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        BUSY        <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_ID      <= id_reg;
                        RSP_ERR     <= PSLVERR;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_RDATA   <= PWRITE ? 32'h0 : PRDATA;
                        state_reg   <= IDLE;
                    end else if (TO_EN && (cnt_next == CNT_LIMIT)) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        BUSY        <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_ID      <= id_reg;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_RDATA   <= 32'h0;
                        state_reg   <= IDLE;
                    end else if (TO_EN) begin
                        cnt_reg <= cnt_next;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed testbench for apb_req_arbiter. Instance dut uses a 16-cycle
// timeout. Instance dut_nt has the timeout disabled. The APB slave signals
// are shared between the two instances. Each instance only runs when its own
// requests are asserted.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int TMO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;

    logic        REQ0_VALID = 1'b0, REQ0_WRITE = 1'b0;
    logic [31:0] REQ0_ADDR = '0, REQ0_WDATA = '0;
    logic        REQ1_VALID = 1'b0, REQ1_WRITE = 1'b0;
    logic [31:0] REQ1_ADDR = '0, REQ1_WDATA = '0;

    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b1;
    logic        PSLVERR = 1'b0;

    logic        GNT0, GNT1, RSP_VALID, RSP_ID, RSP_ERR, RSP_TIMEOUT, BUSY;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] RSP_RDATA, PADDR, PWDATA;

    // second instance, timeout disabled
    logic        b_req0_valid = 1'b0;
    logic [31:0] b_req0_addr = '0;
    logic        b_gnt0, b_gnt1, b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_timeout, b_busy;
    logic        b_psel, b_penable, b_pwrite;
    logic [31:0] b_rsp_rdata, b_paddr, b_pwdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .GNT0(GNT0), .GNT1(GNT1),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_req_arbiter #(.TIMEOUT_CYCLES(0)) dut_nt (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ0_VALID(b_req0_valid), .REQ0_WRITE(1'b0), .REQ0_ADDR(b_req0_addr), .REQ0_WDATA(32'h0),
        .REQ1_VALID(1'b0), .REQ1_WRITE(1'b0), .REQ1_ADDR(32'h0), .REQ1_WDATA(32'h0),
        .GNT0(b_gnt0), .GNT1(b_gnt1),
        .RSP_VALID(b_rsp_valid), .RSP_ID(b_rsp_id), .RSP_RDATA(b_rsp_rdata), .RSP_ERR(b_rsp_err),
        .RSP_TIMEOUT(b_rsp_timeout), .BUSY(b_busy),
        .PSELx(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/ctl"}, {22'b0, GNT0, GNT1, RSP_VALID, RSP_ID, RSP_ERR, RSP_TIMEOUT,
                              BUSY, PSELx, PENABLE, PWRITE}, 32'h0);
        check({tag, "/paddr"}, PADDR, 32'h0);
        check({tag, "/pwdata"}, PWDATA, 32'h0);
        check({tag, "/rdata"}, RSP_RDATA, 32'h0);
    endtask

    // Runs one transfer on dut, from the grant through the response. On entry
    // the requests are already set up. On exit the bench sits 1 ns after the
    // response edge.
    task automatic xfer(input string tag, input logic exp_id, input int waits,
                        input logic [31:0] rdata, input logic slverr, input logic drop);
        int          gwait, k, pen_cnt, exp_k;
        logic        exp_to, exp_write;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;

        exp_write = exp_id ? REQ1_WRITE : REQ0_WRITE;
        exp_addr  = exp_id ? REQ1_ADDR  : REQ0_ADDR;
        exp_wdata = exp_id ? REQ1_WDATA : REQ0_WDATA;
        exp_to    = (TMO != 0) && (waits >= TMO);
        // Response edge, counted from the grant edge t.
        exp_k     = exp_to ? (1 + TMO) : (2 + waits);
        exp_rdata = (exp_write || exp_to) ? 32'h0 : rdata;

        gwait = 0;
        do begin
            @(posedge PCLK); #1;
            gwait++;
        end while (!(GNT0 || GNT1) && gwait < 8);

        // edge t: grant and SETUP
        check({tag, "/grant_wait"}, gwait, 1);
        check({tag, "/gnt"}, {30'b0, GNT1, GNT0}, exp_id ? 32'd2 : 32'd1);
        check({tag, "/setup_sel_en"}, {30'b0, PSELx, PENABLE}, 32'd2);
        check({tag, "/setup_rspv_busy"}, {30'b0, RSP_VALID, BUSY}, 32'd1);
        check({tag, "/pwrite"}, {31'b0, PWRITE}, {31'b0, exp_write});
        check({tag, "/paddr"}, PADDR, exp_addr);
        check({tag, "/pwdata"}, PWDATA, exp_wdata);

        if (drop) begin
            if (exp_id) REQ1_VALID = 1'b0;
            else        REQ0_VALID = 1'b0;
        end
        PRDATA  = rdata;
        PSLVERR = slverr;

        // edge t+1: ACCESS begins
        @(posedge PCLK); #1;
        check({tag, "/access_gnt"}, {30'b0, GNT1, GNT0}, 32'd0);
        check({tag, "/access_sel_en"}, {30'b0, PSELx, PENABLE}, 32'd3);
        pen_cnt = PENABLE ? 1 : 0;

        for (k = 2; k < 64; k++) begin
            PREADY = ((k - 2) >= waits);
            @(posedge PCLK); #1;
            if (RSP_VALID) break;
            if (PENABLE && PSELx) pen_cnt++;
        end

        check({tag, "/rsp_edge"}, k, exp_k);
        check({tag, "/penable_cycles"}, pen_cnt, exp_k - 1);
        check({tag, "/rsp_id"}, {31'b0, RSP_ID}, {31'b0, exp_id});
        check({tag, "/rsp_err"}, {31'b0, RSP_ERR}, {31'b0, exp_to | slverr});
        check({tag, "/rsp_timeout"}, {31'b0, RSP_TIMEOUT}, {31'b0, exp_to});
        check({tag, "/rsp_rdata"}, RSP_RDATA, exp_rdata);
        check({tag, "/done_sel_en_busy"}, {29'b0, PSELx, PENABLE, BUSY}, 32'd0);
        $display("xfer %s: id=%0d write=%0d addr=0x%08h rsp_edge=t+%0d err=%0d tmo=%0d rdata=0x%08h",
                 tag, RSP_ID, exp_write, exp_addr, k, RSP_ERR, RSP_TIMEOUT, RSP_RDATA);
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pen, rsp, gw;

        // Reset state
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_all_zero("reset");
        check("reset/busy_nt", {31'b0, b_busy}, 32'h0);
        PRESETn = 1'b1;

        // Zero-wait write from REQ0; PRDATA must not leak into a write response
        REQ0_WRITE = 1'b1; REQ0_ADDR = 32'h04; REQ0_WDATA = 32'h0000_1234; REQ0_VALID = 1'b1;
        xfer("wr0", 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Read from REQ1 with three wait states
        REQ1_WRITE = 1'b0; REQ1_ADDR = 32'h0C; REQ1_VALID = 1'b1;
        xfer("rd1_wait", 1'b1, 3, 32'hA5A5_0001, 1'b0, 1'b1);

        // Round-robin with both requests held
        REQ0_WRITE = 1'b0; REQ0_ADDR = 32'h10; REQ0_VALID = 1'b1;
        REQ1_WRITE = 1'b1; REQ1_ADDR = 32'h20; REQ1_WDATA = 32'h0000_0055; REQ1_VALID = 1'b1;
        xfer("rr0", 1'b0, 0, 32'h1111_0000, 1'b0, 1'b0);
        xfer("rr1", 1'b1, 1, 32'h2222_0000, 1'b0, 1'b0);
        xfer("rr2", 1'b0, 2, 32'h3333_0000, 1'b0, 1'b0);
        xfer("rr3", 1'b1, 0, 32'h4444_0000, 1'b0, 1'b0);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

        // Slave error, then a clean transfer
        REQ0_WRITE = 1'b1; REQ0_ADDR = 32'h30; REQ0_WDATA = 32'hCAFE_0030; REQ0_VALID = 1'b1;
        xfer("slverr", 1'b0, 0, 32'h0, 1'b1, 1'b1);
        REQ1_WRITE = 1'b0; REQ1_ADDR = 32'h34; REQ1_VALID = 1'b1;
        xfer("after_err", 1'b1, 0, 32'h0BAD_F00D, 1'b0, 1'b1);

        // PREADY on the last allowed wait cycle completes normally
        REQ0_WRITE = 1'b0; REQ0_ADDR = 32'h40; REQ0_VALID = 1'b1;
        xfer("edge15", 1'b0, TMO - 1, 32'h1357_9BDF, 1'b0, 1'b1);

        // PREADY stuck low: abort after TMO wait cycles
        REQ1_WRITE = 1'b0; REQ1_ADDR = 32'h44; REQ1_VALID = 1'b1;
        xfer("tmo", 1'b1, 100, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Timeout disabled: 30 wait cycles, then completion
        b_req0_addr = 32'h50; b_req0_valid = 1'b1;
        gw = 0;
        do begin
            @(posedge PCLK); #1;
            gw++;
        end while (!b_gnt0 && gw < 8);
        check("nt/grant", {31'b0, b_gnt0}, 32'h1);
        b_req0_valid = 1'b0;
        PREADY = 1'b0;
        PRDATA = 32'h2468_ACE0;
        pen = 0; rsp = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge PCLK); #1;
            if (b_penable) pen++;
            if (b_rsp_valid) rsp++;
        end
        check("nt/no_rsp_while_waiting", rsp, 0);
        check("nt/penable_cycles", pen, 30);
        PREADY = 1'b1;
        @(posedge PCLK); #1;
        check("nt/rsp_valid", {31'b0, b_rsp_valid}, 32'h1);
        check("nt/rsp_err_tmo", {30'b0, b_rsp_err, b_rsp_timeout}, 32'h0);
        check("nt/rsp_rdata", b_rsp_rdata, 32'h2468_ACE0);
        $display("xfer nt: id=%0d rsp_valid=%0d err=%0d tmo=%0d rdata=0x%08h",
                 b_rsp_id, b_rsp_valid, b_rsp_err, b_rsp_timeout, b_rsp_rdata);

        // Reset mid-transfer. The aborted transfer belongs to REQ0, so the
        // tie afterwards only goes to REQ0 if the grant pointer was reset.
        REQ0_WRITE = 1'b1; REQ0_ADDR = 32'h60; REQ0_WDATA = 32'h6060_6060; REQ0_VALID = 1'b1;
        gw = 0;
        do begin
            @(posedge PCLK); #1;
            gw++;
        end while (!GNT0 && gw < 8);
        check("mid/grant", {31'b0, GNT0}, 32'h1);
        REQ1_WRITE = 1'b0; REQ1_ADDR = 32'h64; REQ1_VALID = 1'b1;
        PREADY = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("mid/in_access", {30'b0, PSELx, PENABLE}, 32'd3);
        #2 PRESETn = 1'b0;
        #1;
        check_all_zero("mid_async");
        repeat (2) @(posedge PCLK);
        #1;
        check("mid/held_in_reset", {29'b0, RSP_VALID, GNT0, GNT1}, 32'h0);
        #3 PRESETn = 1'b1;
        PREADY = 1'b1;
        xfer("post_rst", 1'b0, 0, 32'h7777_7777, 1'b0, 1'b1);
        REQ1_VALID = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
